slicer_sched: RTL

Round-robin scheduler that shares one sign-decision slicer (MSB-based hard decision to +1.0 / -1.0 two's complement) between `NUM_REQ` sample requesters. It sits between the equalizer/filter taps that produce soft samples and the downstream decision consumer. It arbitrates with valid/ready handshakes and registers one decision per cycle, tagged with the requester ID. It also keeps a running count of decisions issued.

---
 rtl/slicer_pkg.sv | 35 +++
 rtl/slicer_sched_if.sv | 43 ++++
 rtl/sign_slicer.sv | 21 ++
 rtl/slicer_sched.sv | 109 ++++++++++
 4 files changed

// File: rtl/slicer_pkg.sv
// Shared constants and helpers for the shared sign-slicer scheduler.
package slicer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Index width for n items, never below one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // +1 in a w-bit two's complement word.
    function automatic logic [31:0] dec_pos(input int unsigned w);
        return (w >= 2) ? 32'd1 : 32'd0;
    endfunction

    // -1 (all ones) in a w-bit two's complement word.
    function automatic logic [31:0] dec_neg(input int unsigned w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/slicer_sched_if.sv
// Requester and decision-consumer handshake bundle for slicer_sched.
interface slicer_sched_if #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_IN_WIDTH  = 8,
    parameter int unsigned DATA_OUT_WIDTH = 4,
    parameter int unsigned CNT_WIDTH      = 16
);
    import slicer_pkg::*;

    localparam int unsigned ID_WIDTH = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]               i_req_valid;
    logic [NUM_REQ*DATA_IN_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]               o_req_ready;
    logic                             o_dec_valid;
    logic [DATA_OUT_WIDTH-1:0]        o_dec_data;
    logic [ID_WIDTH-1:0]              o_dec_id;
    logic                             i_dec_ready;
    logic [CNT_WIDTH-1:0]             o_dec_count;

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        input  i_dec_ready,
        output o_req_ready,
        output o_dec_valid,
        output o_dec_data,
        output o_dec_id,
        output o_dec_count
    );

    modport master (
        output i_req_valid,
        output i_req_data,
        output i_dec_ready,
        input  o_req_ready,
        input  o_dec_valid,
        input  o_dec_data,
        input  o_dec_id,
        input  o_dec_count
    );

endinterface

// File: rtl/sign_slicer.sv
// Hard sign decision: MSB clear (including zero) gives +1, MSB set gives -1.
module sign_slicer
    import slicer_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH  = 8,
    parameter int unsigned DATA_OUT_WIDTH = 4
) (
    input  logic [DATA_IN_WIDTH-1:0]  sample,
    output logic [DATA_OUT_WIDTH-1:0] decision_c
);

    localparam logic [DATA_OUT_WIDTH-1:0] DEC_POS = DATA_OUT_WIDTH'(dec_pos(DATA_OUT_WIDTH));
    localparam logic [DATA_OUT_WIDTH-1:0] DEC_NEG = DATA_OUT_WIDTH'(dec_neg(DATA_OUT_WIDTH));

    // Only the sign bit matters; the magnitude bits are deliberately dropped.
    logic unused_mag;
    assign unused_mag = ^sample[DATA_IN_WIDTH-2:0];

    assign decision_c = sample[DATA_IN_WIDTH-1] ? DEC_NEG : DEC_POS;

endmodule

// File: rtl/slicer_sched.sv
// Round-robin arbiter sharing one sign slicer across NUM_REQ requesters,
// with a single registered decision slot and an accepted-decision counter.
module slicer_sched
    import slicer_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_IN_WIDTH  = 8,
    parameter int unsigned DATA_OUT_WIDTH = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    slicer_sched_if.slave bus
);

    localparam int unsigned ID_WIDTH = clog2(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

    slot_state_e               state;
    logic [ID_WIDTH-1:0]       last_grant;
    logic [ID_WIDTH-1:0]       sel_idx;
    logic                      sel_found;
    logic                      slot_free;
    logic                      xfer;
    logic [NUM_REQ-1:0]        grant_c;
    logic [DATA_IN_WIDTH-1:0]  sel_sample;
    logic [DATA_OUT_WIDTH-1:0] sel_dec;
    logic [DATA_OUT_WIDTH-1:0] dec_data_q;
    logic [ID_WIDTH-1:0]       dec_id_q;
    logic [CNT_WIDTH-1:0]      count_q;

    assign slot_free = (state == ST_EMPTY) || bus.i_dec_ready;

    // First valid requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin : rr_search
        int unsigned         idx;
        logic [ID_WIDTH-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = last_grant;
        idx       = 32'(last_grant);
        cand      = last_grant;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx  = rr_next(idx, NUM_REQ);
            cand = ID_WIDTH'(idx);
            if (!sel_found && bus.i_req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin : grant_gen
        grant_c = '0;
        if (slot_free && sel_found && !i_rst) begin
            grant_c[sel_idx] = 1'b1;
        end
    end

    assign xfer            = slot_free && sel_found && !i_rst;
    assign bus.o_req_ready = grant_c;
    assign sel_sample      = bus.i_req_data[32'(sel_idx) * DATA_IN_WIDTH +: DATA_IN_WIDTH];

    sign_slicer #(
        .DATA_IN_WIDTH (DATA_IN_WIDTH),
        .DATA_OUT_WIDTH(DATA_OUT_WIDTH)
    ) u_slicer (
        .sample    (sel_sample),
        .decision_c(sel_dec)
    );

    // Slot FSM, priority pointer and counter; slot contents hold under stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_EMPTY;
            dec_data_q <= '0;
            dec_id_q   <= '0;
            count_q    <= '0;
            last_grant <= LAST_RST;
        end else begin
            if ((state == ST_FULL) && bus.i_dec_ready) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (xfer) begin
                dec_data_q <= sel_dec;
                dec_id_q   <= sel_idx;
                last_grant <= sel_idx;
            end
            unique case (state)
                ST_EMPTY: begin
                    if (xfer) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!xfer && bus.i_dec_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.o_dec_valid = (state == ST_FULL);
    assign bus.o_dec_data  = dec_data_q;
    assign bus.o_dec_id    = dec_id_q;
    assign bus.o_dec_count = count_q;

endmodule
